// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
// Defines depth limit, stall counter width and occupancy width helper.
package pipe_reg_pkg;

  localparam int MAX_DEPTH   = 8;
  localparam int STALL_CNT_W = 16;

  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One elastic stage: a valid bit plus a WIDTH data register.
// Ports: clk, rst_n, i_flush, i_load, i_valid, i_data -> o_valid, o_data.
module pipe_reg_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Data only moves with a valid item, so bubbles never toggle it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VAL;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage pipeline register with valid/ready and flush.
// Ports: clk, rst_n, flush, in_valid/in_ready/in_data,
//   out_valid/out_ready/out_data, occupancy, stall_cnt.
// Macro PIPE_REG_CHAIN_STALL_CNT_EN builds the saturating stall counter.
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [occ_width(DEPTH)-1:0] occupancy,
  output logic [STALL_CNT_W-1:0]      stall_cnt
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_vin;
  logic [WIDTH-1:0] w_d   [DEPTH];
  logic [WIDTH-1:0] w_din [DEPTH];
  logic [OCC_W-1:0] w_occ;

  // Ready ripples from the output back to the input; an empty
  // stage is always ready, which collapses bubbles under stall.
  always_comb begin
    w_rdy = '0;
    w_rdy[DEPTH-1] = ~w_v[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_rdy[i] = ~w_v[i] | w_rdy[i+1];
    end
  end

  assign in_ready = w_rdy[0] & ~flush & rst_n;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign w_vin[g] = in_valid & in_ready;
        assign w_din[g] = in_data;
      end else begin : g_body
        assign w_vin[g] = w_v[g-1];
        assign w_din[g] = w_d[g-1];
      end

      pipe_reg_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_load  (w_rdy[g]),
        .i_valid (w_vin[g]),
        .i_data  (w_din[g]),
        .o_valid (w_v[g]),
        .o_data  (w_d[g])
      );
    end
  endgenerate

  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(w_v[i]);
    end
  end

  assign occupancy = w_occ;

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  stall_cnt_t r_stall_cnt;

  // Saturates; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain at DEPTH 2, 3 and 4.
// Table vectors drive the DEPTH=3 chain; hand sequences cover corners.
module tb_pipe_reg_chain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fl = 1'b0;
  logic        iv = 1'b0;
  logic [31:0] id = '0;
  logic        ord = 1'b0;

  logic        ir3, ov3, ir2, ov2, ir4, ov4;
  logic [31:0] od3, od2, od4;
  logic [1:0]  oc3, oc2;
  logic [2:0]  oc4;
  logic [15:0] sc3, sc2, sc4;

  int n_vec = 0;
  int n_bad = 0;

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd5;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(fl),
    .in_valid(iv), .in_ready(ir3), .in_data(id),
    .out_valid(ov3), .out_ready(ord), .out_data(od3),
    .occupancy(oc3), .stall_cnt(sc3)
  );

  pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(fl),
    .in_valid(iv), .in_ready(ir2), .in_data(id),
    .out_valid(ov2), .out_ready(ord), .out_data(od2),
    .occupancy(oc2), .stall_cnt(sc2)
  );

  pipe_reg_chain #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'h0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(fl),
    .in_valid(iv), .in_ready(ir4), .in_data(id),
    .out_valid(ov4), .out_ready(ord), .out_data(od4),
    .occupancy(oc4), .stall_cnt(sc4)
  );

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ord;
    logic        fl;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    logic [1:0]  occ;
  } vec_t;

  vec_t tv[$];

  function automatic void add(
    input logic iv_, input logic [31:0] id_,
    input logic ord_, input logic fl_,
    input logic ov_, input logic [31:0] od_,
    input logic ir_, input logic [1:0] occ_);
    vec_t v;
    v.iv = iv_; v.id = id_; v.ord = ord_; v.fl = fl_;
    v.ov = ov_; v.od = od_; v.ir = ir_; v.occ = occ_;
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    iv = 1'b0; id = '0; ord = 1'b0; fl = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // iv  id      ord fl | ov  od     ir occ
    // streaming 0x10..0x17
    add(1, 32'h10, 1, 0, 0, 32'h00, 1, 0);
    add(1, 32'h11, 1, 0, 0, 32'h00, 1, 1);
    add(1, 32'h12, 1, 0, 0, 32'h00, 1, 2);
    add(1, 32'h13, 1, 0, 1, 32'h10, 1, 3);
    add(1, 32'h14, 1, 0, 1, 32'h11, 1, 3);
    add(1, 32'h15, 1, 0, 1, 32'h12, 1, 3);
    add(1, 32'h16, 1, 0, 1, 32'h13, 1, 3);
    add(1, 32'h17, 1, 0, 1, 32'h14, 1, 3);
    add(0, 32'h00, 1, 0, 1, 32'h15, 1, 3);
    add(0, 32'h00, 1, 0, 1, 32'h16, 1, 2);
    add(0, 32'h00, 1, 0, 1, 32'h17, 1, 1);
    add(0, 32'h00, 1, 0, 0, 32'h17, 1, 0);
    // backpressure, bubble collapse, full
    add(1, 32'h01, 0, 0, 0, 32'h17, 1, 0);
    add(0, 32'h00, 0, 0, 0, 32'h17, 1, 1);
    add(1, 32'h02, 0, 0, 0, 32'h17, 1, 1);
    add(0, 32'h00, 0, 0, 1, 32'h01, 1, 2);
    add(0, 32'h00, 0, 0, 1, 32'h01, 1, 2);
    add(1, 32'h03, 0, 0, 1, 32'h01, 1, 2);
    add(0, 32'h00, 0, 0, 1, 32'h01, 0, 3);
    add(1, 32'hEE, 0, 0, 1, 32'h01, 0, 3);
    add(0, 32'h00, 1, 0, 1, 32'h01, 1, 3);
    add(0, 32'h00, 1, 0, 1, 32'h02, 1, 2);
    add(0, 32'h00, 1, 0, 1, 32'h03, 1, 1);
    add(0, 32'h00, 1, 0, 0, 32'h03, 1, 0);
    // flush drops offered data and clears partial contents
    add(1, 32'hA0, 0, 0, 0, 32'h03, 1, 0);
    add(1, 32'hA1, 0, 0, 0, 32'h03, 1, 1);
    add(1, 32'hA2, 0, 1, 0, 32'h03, 0, 2);
    add(0, 32'h00, 1, 0, 0, 32'h03, 1, 0);
    add(0, 32'h00, 1, 0, 0, 32'h03, 1, 0);

    // reset state
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(ir3), 32'h0);
    do_reset;
    chk("rst_ov", 32'(ov3), 32'h0);
    chk("rst_od", od3, 32'h0);
    chk("rst_occ", 32'(oc3), 32'h0);
    chk("rst_sc3", 32'(sc3), 32'h0);
    chk("rst_sc2", 32'(sc2), 32'h0);
    chk("rst_sc4", 32'(sc4), 32'h0);
    chk("rst_ir_rel", 32'(ir3), 32'h1);

    // table
    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      iv = tv[k].iv; id = tv[k].id;
      ord = tv[k].ord; fl = tv[k].fl;
      #1;
      chk($sformatf("v%0d_ov", k), 32'(ov3), 32'(tv[k].ov));
      chk($sformatf("v%0d_od", k), od3, tv[k].od);
      chk($sformatf("v%0d_ir", k), 32'(ir3), 32'(tv[k].ir));
      chk($sformatf("v%0d_occ", k), 32'(oc3), 32'(tv[k].occ));
    end

    // asynchronous reset mid-stream
    do_reset;
    @(negedge clk); iv = 1; id = 32'hA1; ord = 0;
    @(negedge clk); id = 32'hA2;
    @(negedge clk); iv = 0;
    @(negedge clk); #1;
    chk("mid_ov_pre", 32'(ov3), 32'h1);
    chk("mid_od_pre", od3, 32'hA1);
    rst_n = 1'b0;
    #1;
    chk("mid_ov", 32'(ov3), 32'h0);
    chk("mid_occ", 32'(oc3), 32'h0);
    chk("mid_od", od3, 32'h0);
    chk("mid_ir", 32'(ir3), 32'h0);

    // DEPTH=2 push and pop together while full
    do_reset;
    @(negedge clk); iv = 1; id = 32'h55; ord = 0;
    @(negedge clk); id = 32'h66;
    @(negedge clk); id = 32'h77; #1;
    chk("d2_full_ir", 32'(ir2), 32'h0);
    chk("d2_full_occ", 32'(oc2), 32'h2);
    ord = 1; #1;
    chk("d2_pp_ir", 32'(ir2), 32'h1);
    chk("d2_pp_od", od2, 32'h55);
    @(negedge clk); iv = 0; #1;
    chk("d2_pp_occ", 32'(oc2), 32'h2);
    chk("d2_pp_od2", od2, 32'h66);
    @(negedge clk); #1;
    chk("d2_last_od", od2, 32'h77);
    chk("d2_last_occ", 32'(oc2), 32'h1);
    @(negedge clk); #1;
    chk("d2_empty_ov", 32'(ov2), 32'h0);

    // DEPTH=4 flush with three items held
    do_reset;
    @(negedge clk); iv = 1; id = 32'hB1; ord = 0;
    @(negedge clk); id = 32'hB2;
    @(negedge clk); id = 32'hB3;
    @(negedge clk); id = 32'h99; fl = 1; #1;
    chk("d4_pre_occ", 32'(oc4), 32'h3);
    chk("d4_fl_ir", 32'(ir4), 32'h0);
    @(negedge clk); fl = 0; iv = 0; ord = 1; #1;
    chk("d4_fl_occ", 32'(oc4), 32'h0);
    chk("d4_fl_ov", 32'(ov4), 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      chk($sformatf("d4_drain%0d_ov", c), 32'(ov4), 32'h0);
    end
    chk("d4_od_kept", od4, 32'h0);

    // stall counter: five stalled cycles, then a flush
    do_reset;
    @(negedge clk); iv = 1; id = 32'h5A; ord = 0;
    @(negedge clk); iv = 0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        #1;
        if (ov3) seen = 1'b1;
        else @(negedge clk);
      end
      chk("sc_wait_ov", 32'(seen), 32'h1);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk($sformatf("sc_hold%0d_od", c), od3, 32'h5A);
    end
    chk("sc_count", 32'(sc3), 32'(EXP_STALL));
    fl = 1; ord = 1;
    @(negedge clk); fl = 0; ord = 0; #1;
    chk("sc_after_fl", 32'(sc3), 32'(EXP_STALL));
    chk("sc_fl_ov", 32'(ov3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
